// File: rtl/alarm_controller_if.sv
// Time-of-day, alarm-table and operator-control bundle for alarm_controller.
// The master drives time, alarm settings and STOP/SNOOZE; the slave returns the ringer status.
interface alarm_controller_if #(
  parameter int N_ALARMS = 4
);
  logic [3:0]            TIME_HRS;
  logic [5:0]            TIME_MINS;
  logic                  TIME_AM_PM;
  logic [4*N_ALARMS-1:0] ALARM_HRS;
  logic [6*N_ALARMS-1:0] ALARM_MINS;
  logic [N_ALARMS-1:0]   ALARM_AM_PM;
  logic [N_ALARMS-1:0]   ALARM_EN;
  logic                  STOP;
  logic                  SNOOZE;
  logic                  RINGER;
  logic [2:0]            ACTIVE_CH;
  logic                  SNOOZING;

  modport master (
    output TIME_HRS, TIME_MINS, TIME_AM_PM,
    output ALARM_HRS, ALARM_MINS, ALARM_AM_PM, ALARM_EN,
    output STOP, SNOOZE,
    input  RINGER, ACTIVE_CH, SNOOZING
  );

  modport slave (
    input  TIME_HRS, TIME_MINS, TIME_AM_PM,
    input  ALARM_HRS, ALARM_MINS, ALARM_AM_PM, ALARM_EN,
    input  STOP, SNOOZE,
    output RINGER, ACTIVE_CH, SNOOZING
  );
endinterface

// File: rtl/alarm_controller.sv
// Multi-channel alarm: edge-triggered time match drives a ring/snooze sequencer; RINGER rises 1 cycle after the match edge.
// Registered outputs, no backpressure (STOP/SNOOZE are level-sampled); the snooze path exists only when ALARM_SNOOZE_EN is defined.
module alarm_controller #(
  parameter int N_ALARMS      = 4,
  parameter int RING_CYCLES   = 60,
  parameter int SNOOZE_CYCLES = 300
) (
  input logic                CLK,
  input logic                RESET_N,
  alarm_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam logic [15:0] RING_LOAD = 16'(RING_CYCLES - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          ch_q, ch_d;
  logic [N_ALARMS-1:0] match_d, match_q, trigger;
  logic [2:0]          sel_ch;
  logic                any_trig;
  logic [7:0]          en_ext;
  logic                en_lost;
  logic                ringer_q;

`ifdef ALARM_SNOOZE_EN
  localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_CYCLES - 1);
  logic                snoozing_q;
`else
  logic                unused_snooze;
  assign unused_snooze = ^{bus.SNOOZE, 16'(SNOOZE_CYCLES)};
`endif

  always_comb begin
    match_d = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      match_d[i] = bus.ALARM_EN[i]
                && (bus.ALARM_HRS[4*i +: 4]  == bus.TIME_HRS)
                && (bus.ALARM_MINS[6*i +: 6] == bus.TIME_MINS)
                && (bus.ALARM_AM_PM[i]       == bus.TIME_AM_PM);
    end
  end

  // Only the rising edge of a match fires, so a held minute rings once.
  assign trigger  = match_d & ~match_q;
  assign any_trig = |trigger;

  always_comb begin
    sel_ch = 3'd0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (trigger[i]) sel_ch = 3'(i);
    end
  end

  assign en_ext  = 8'(bus.ALARM_EN);
  assign en_lost = (state_q != ST_IDLE) && !en_ext[ch_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_trig) begin
          state_d = ST_RINGING;
          ch_d    = sel_ch;
          cnt_d   = RING_LOAD;
        end
      end
      ST_RINGING: begin
        if (bus.STOP) begin
          state_d = ST_IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (bus.SNOOZE) begin
          state_d = ST_SNOOZE;
          cnt_d   = SNOOZE_LOAD;
        end
`endif
        else if (cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
        if (bus.STOP) begin
          state_d = ST_IDLE;
        end else if (any_trig) begin
          state_d = ST_RINGING;
          ch_d    = sel_ch;
          cnt_d   = RING_LOAD;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_RINGING;
          cnt_d   = RING_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the owning channel cancels the event regardless of anything else.
    if (en_lost) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      match_q    <= '1;
      ringer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snoozing_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      match_q    <= match_d;
      ringer_q   <= (state_d == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
      snoozing_q <= (state_d == ST_SNOOZE);
`endif
    end
  end

  assign bus.RINGER    = ringer_q;
  assign bus.ACTIVE_CH = ch_q;
`ifdef ALARM_SNOOZE_EN
  assign bus.SNOOZING  = snoozing_q;
`else
  assign bus.SNOOZING  = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: deadline-based reference model checked every cycle, plus directed literal checks.
module tb_alarm_controller;
  localparam int N      = 4;
  localparam int RING   = 60;
  localparam int SNZ    = 300;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  logic CLK     = 1'b0;
  logic RESET_N = 1'b1;
  int   tests   = 0;
  int   fails   = 0;
  bit   cmp_en  = 1'b0;

  always #5 CLK = ~CLK;

  alarm_controller_if #(.N_ALARMS(N)) bus ();

  alarm_controller #(
    .N_ALARMS(N), .RING_CYCLES(RING), .SNOOZE_CYCLES(SNZ)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  // Reference model: tracks the current phase and the absolute edge at which it times out.
  typedef enum {M_IDLE, M_RING, M_SNZ} mmode_e;
  mmode_e   m_mode     = M_IDLE;
  int       m_ch       = 0;
  longint   m_deadline = 0;
  longint   edge_n     = 0;
  bit [N-1:0] m_prev   = '1;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_mode = M_IDLE;
      m_ch   = 0;
      m_prev = '1;
    end else begin
      int first;
      edge_n++;
      first = -1;
      for (int i = N - 1; i >= 0; i--) begin
        bit m;
        m = bus.ALARM_EN[i] && (bus.ALARM_HRS[4*i +: 4] == bus.TIME_HRS)
            && (bus.ALARM_MINS[6*i +: 6] == bus.TIME_MINS)
            && (bus.ALARM_AM_PM[i] == bus.TIME_AM_PM);
        if (m && !m_prev[i]) first = i;
        m_prev[i] = m;
      end
      if (m_mode != M_IDLE && !bus.ALARM_EN[m_ch]) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (first >= 0) begin
            m_mode = M_RING; m_ch = first; m_deadline = edge_n + RING;
          end
          M_RING: begin
            if (bus.STOP) m_mode = M_IDLE;
            else if (SNOOZE_ON && bus.SNOOZE) begin
              m_mode = M_SNZ; m_deadline = edge_n + SNZ;
            end else if (edge_n == m_deadline) m_mode = M_IDLE;
          end
          M_SNZ: begin
            if (bus.STOP) m_mode = M_IDLE;
            else if (first >= 0) begin
              m_mode = M_RING; m_ch = first; m_deadline = edge_n + RING;
            end else if (edge_n == m_deadline) begin
              m_mode = M_RING; m_deadline = edge_n + RING;
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      int er, es;
      er = (m_mode == M_RING) ? 1 : 0;
      es = (m_mode == M_SNZ) ? 1 : 0;
      tests++;
      if (bus.RINGER !== 1'(er) || bus.SNOOZING !== 1'(es) || bus.ACTIVE_CH !== 3'(m_ch)) begin
        fails++;
        $display("FAIL model_cmp: got ringer=%b snoozing=%b ch=%0d, expected ringer=%0d snoozing=%0d ch=%0d (t=%0t)",
                 bus.RINGER, bus.SNOOZING, bus.ACTIVE_CH, er, es, m_ch, $time);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_time(int h, int m, bit pm);
    bus.TIME_HRS   = 4'(h);
    bus.TIME_MINS  = 6'(m);
    bus.TIME_AM_PM = pm;
  endtask

  task automatic set_alarm(int ch, int h, int m, bit pm, bit en);
    bus.ALARM_HRS[4*ch +: 4]  = 4'(h);
    bus.ALARM_MINS[6*ch +: 6] = 6'(m);
    bus.ALARM_AM_PM[ch]       = pm;
    bus.ALARM_EN[ch]          = en;
  endtask

  task automatic count_cycles(int ncyc, output int n_ring, output int n_snz);
    n_ring = 0;
    n_snz  = 0;
    repeat (ncyc) begin
      @(negedge CLK);
      if (bus.RINGER)   n_ring++;
      if (bus.SNOOZING) n_snz++;
    end
  endtask

  // Break the match then restore it; ringing starts on the first edge after restore.
  task automatic retrigger(int h, int m, bit pm);
    set_time(h, m, !pm);
    step(2);
    set_time(h, m, pm);
    step(3);
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int r, s;
    bus.ALARM_HRS = '0; bus.ALARM_MINS = '0; bus.ALARM_AM_PM = '0; bus.ALARM_EN = '0;
    bus.STOP = 1'b0; bus.SNOOZE = 1'b0;
    set_time(12, 0, 0);
    #1 RESET_N = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset with a time that already matches ch0: no ring on release.
    set_alarm(0, 7, 30, 0, 1);
    set_time(7, 30, 0);
    step(3);
    @(negedge CLK);
    check("reset_ringer", bus.RINGER, 0);
    check("reset_snoozing", bus.SNOOZING, 0);
    check("reset_ch", bus.ACTIVE_CH, 0);
    step(1);
    RESET_N = 1'b1;
    count_cycles(10, r, s);
    check("no_ring_at_release", r, 0);

    // Ch0 7:30 AM: one-cycle latency, 60-cycle ring, no re-ring while held.
    step(1);
    set_time(7, 29, 0);
    step(2);
    set_time(7, 30, 0);
    @(negedge CLK);
    check("latency_pre", bus.RINGER, 0);
    @(negedge CLK);
    check("latency_ring", bus.RINGER, 1);
    check("latency_ch", bus.ACTIVE_CH, 0);
    count_cycles(99, r, s);
    check("ring_length", r + 1, 60);
    count_cycles(60, r, s);
    check("no_rering_held", r, 0);

    // Ch1 and ch3 both 6:00 PM: lowest index wins; ch2 trigger during ring ignored.
    step(1);
    set_alarm(0, 7, 30, 0, 0);
    set_alarm(1, 6, 0, 1, 1);
    set_alarm(3, 6, 0, 1, 1);
    set_alarm(2, 6, 1, 1, 1);
    set_time(5, 59, 1);
    step(2);
    set_time(6, 0, 1);
    @(negedge CLK);
    @(negedge CLK);
    check("prio_ringer", bus.RINGER, 1);
    check("prio_ch", bus.ACTIVE_CH, 1);
    step(8);
    set_time(6, 1, 1);
    step(3);
    @(negedge CLK);
    check("ignore_new_ch", bus.ACTIVE_CH, 1);
    check("ignore_new_ringer", bus.RINGER, 1);
    step(1);
    bus.STOP = 1'b1;
    step(1);
    bus.STOP = 1'b0;
    @(negedge CLK);
    check("stop_ringer", bus.RINGER, 0);
    count_cycles(80, r, s);
    check("not_queued", r, 0);

    // Ch2 9:15 AM: clearing its enable drops RINGER on the next cycle.
    step(1);
    set_alarm(1, 6, 0, 1, 0);
    set_alarm(3, 6, 0, 1, 0);
    set_alarm(2, 9, 15, 0, 1);
    set_time(9, 14, 0);
    step(2);
    set_time(9, 15, 0);
    @(negedge CLK);
    @(negedge CLK);
    check("ch2_ringer", bus.RINGER, 1);
    check("ch2_ch", bus.ACTIVE_CH, 2);
    step(1);
    bus.ALARM_EN[2] = 1'b0;
    @(negedge CLK);
    check("en_clear_pre", bus.RINGER, 1);
    @(negedge CLK);
    check("en_clear", bus.RINGER, 0);

    // STOP and SNOOZE together always end the event.
    step(1);
    set_alarm(0, 10, 0, 0, 1);
    retrigger(10, 0, 0);
    bus.STOP = 1'b1;
    bus.SNOOZE = 1'b1;
    step(1);
    bus.STOP = 1'b0;
    bus.SNOOZE = 1'b0;
    @(negedge CLK);
    check("stop_beats_snooze_r", bus.RINGER, 0);
    check("stop_beats_snooze_s", bus.SNOOZING, 0);

`ifdef ALARM_SNOOZE_EN
    // Snooze 300 cycles then ring again on the same channel.
    step(1);
    retrigger(10, 0, 0);
    bus.SNOOZE = 1'b1;
    step(1);
    bus.SNOOZE = 1'b0;
    @(negedge CLK);
    check("snooze_ringer", bus.RINGER, 0);
    check("snooze_flag", bus.SNOOZING, 1);
    count_cycles(400, r, s);
    check("snooze_length", s + 1, 300);
    check("resume_ring", r, 60);

    // A new channel trigger during snooze takes over.
    step(1);
    retrigger(10, 0, 0);
    bus.SNOOZE = 1'b1;
    step(1);
    bus.SNOOZE = 1'b0;
    set_alarm(1, 11, 0, 0, 1);
    step(5);
    set_time(11, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    check("snooze_new_ringer", bus.RINGER, 1);
    check("snooze_new_ch", bus.ACTIVE_CH, 1);
    step(1);
    bus.STOP = 1'b1;
    step(1);
    bus.STOP = 1'b0;
    set_alarm(1, 11, 0, 0, 0);

    // Reset mid-snooze: outputs clear at once, no resumption.
    step(1);
    retrigger(10, 0, 0);
    bus.SNOOZE = 1'b1;
    step(1);
    bus.SNOOZE = 1'b0;
    step(5);
`else
    // Snooze disabled: SNOOZE has no effect on a ring.
    step(1);
    retrigger(10, 0, 0);
    bus.SNOOZE = 1'b1;
    step(1);
    bus.SNOOZE = 1'b0;
    @(negedge CLK);
    check("snooze_ignored_r", bus.RINGER, 1);
    check("snooze_ignored_s", bus.SNOOZING, 0);
    count_cycles(100, r, s);
    check("ring_rest_with_snooze", r, 56);
    check("snoozing_never", s, 0);

    // Reset mid-ring: outputs clear at once, no resumption.
    step(1);
    retrigger(10, 0, 0);
    step(5);
`endif
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_r", bus.RINGER, 0);
    check("async_reset_s", bus.SNOOZING, 0);
    check("async_reset_ch", bus.ACTIVE_CH, 0);
    step(2);
    RESET_N = 1'b1;
    count_cycles(400, r, s);
    check("no_resume_r", r, 0);
    check("no_resume_s", s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter N_ALARMS, default 4: number of independent alarm channels, 1..8.
REQ-002 Parameter RING_CYCLES, default 60: clock cycles RINGER stays high without operator action, 1..65535.
REQ-003 Parameter SNOOZE_CYCLES, default 300: snooze interval length in clock cycles, 1..65535.
REQ-004 Port CLK  in  1: single clock; all state updates on rising edge.
REQ-005 Port RESET_N  in  1: reset, asynchronous, active-low.
REQ-006 Port TIME_HRS  in  4 / TIME_MINS  in  6 / TIME_AM_PM  in  1: current time of day.
REQ-007 Port ALARM_HRS  in  4*N_ALARMS / ALARM_MINS  in  6*N_ALARMS / ALARM_AM_PM  in  N_ALARMS: channel i occupies slice i.
REQ-008 Port ALARM_EN  in  N_ALARMS: per-channel enable.
REQ-009 Port STOP  in  1 / SNOOZE  in  1: operator controls, level-sampled each cycle.
REQ-010 Port RINGER  out  1: alarm sounding.
REQ-011 Port ACTIVE_CH  out  3: index of channel owning current ring/snooze.
REQ-012 Port SNOOZING  out  1: snooze interval in progress.

Function
REQ-013 Channel i SHALL match when ALARM_EN[i]=1 and its HRS, MINS, AM_PM slices equal TIME_HRS, TIME_MINS, TIME_AM_PM exactly.
REQ-014 Match vector SHALL be registered each cycle (match_q); trigger[i] = match[i] AND NOT match_q[i], so a held matching minute fires once only.
REQ-015 Multiple simultaneous triggers SHALL select the lowest index.
REQ-016 States: IDLE, RINGING, SNOOZE; one shared 16-bit down-counter.
REQ-017 IDLE + any trigger -> RINGING, ACTIVE_CH = selected index, counter = RING_CYCLES-1; RINGER high in the cycle after the triggering edge (latency 1).
REQ-018 RINGING: STOP=1 -> IDLE; else SNOOZE=1 -> SNOOZE, counter = SNOOZE_CYCLES-1; else counter=0 -> IDLE; else decrement. STOP SHALL win over SNOOZE.
REQ-019 RINGING: new triggers on other channels SHALL be ignored (not queued).
REQ-020 SNOOZE: STOP=1 -> IDLE; new trigger -> RINGING with new channel and counter reload; counter=0 -> RINGING, same ACTIVE_CH, counter = RING_CYCLES-1; else decrement. SNOOZE input ignored in this state.
REQ-021 Deassertion of ALARM_EN[ACTIVE_CH] in RINGING or SNOOZE SHALL force IDLE next cycle, overriding all other transitions.
REQ-022 RINGER = (state==RINGING); SNOOZING = (state==SNOOZE); both registered, glitch-free.
REQ-023 ACTIVE_CH SHALL hold its value in IDLE until next trigger; upper unused bits zero.

Reset
REQ-024 RESET_N=0 SHALL immediately force IDLE, RINGER=0, SNOOZING=0, ACTIVE_CH=0, counter=0, match_q=all ones (no spurious trigger on a time already matching at reset release).
REQ-025 Reset mid-ring or mid-snooze SHALL abandon the event with no resumption after release.

Configuration
REQ-026 Macro ALARM_SNOOZE_EN defined: SNOOZE state and SNOOZING output behave as above.
REQ-027 Macro ALARM_SNOOZE_EN undefined: SNOOZE input ignored, SNOOZE state unreachable, SNOOZING tied 0, SNOOZE_CYCLES unused; all other behaviour unchanged.

Verification
REQ-028 Ch0 alarm 7:30 AM enabled, time steps to 7:30 AM -> RINGER=1 one cycle later, ACTIVE_CH=0, stays high 60 cycles, then 0; time held 7:30 -> no re-ring.
REQ-029 Ch1 and ch3 both 6:00 PM, time reaches 6:00 PM -> ACTIVE_CH=1; ch3 never rings for that minute.
REQ-030 Ringing, SNOOZE pulsed -> RINGER=0, SNOOZING=1 for 300 cycles, then RINGER=1 same channel; STOP and SNOOZE same cycle -> IDLE.
REQ-031 Ringing ch2, ALARM_EN[2] cleared -> RINGER=0 next cycle; RESET_N low during SNOOZE -> all outputs 0 immediately, no ring after release with time still matching.
REQ-032 Build without ALARM_SNOOZE_EN, SNOOZE pulsed while ringing -> RINGER stays 1 until STOP or 60-cycle timeout, SNOOZING always 0.
